// File: rtl/m_gen_min_hour.sv
// ============================================================================
//  Module   : m_gen_min_hour
//  Purpose  : BCD minutes/hours counter fed by the seconds-stage minute carry,
//             with time-set buttons, 24h or 12h (AM/PM) hour format and a
//             one-cycle day-rollover pulse.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module m_gen_min_hour #(
  parameter bit H24 = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       min_carry,
  input  logic       set_en,
  input  logic       btn_min,
  input  logic       btn_hour,
  output logic [3:0] min_low,
  output logic [3:0] min_high,
  output logic [3:0] hour_low,
  output logic [3:0] hour_high,
  output logic       pm,
  output logic       day_pulse
);

  // Edge-detect history. The "arm" bit is only set once the raw input has
  // actually been sampled low, so a level that is already high when reset
  // releases cannot masquerade as a fresh rising edge.
  logic carry_s1, carry_s2, carry_arm;
  logic bmin_s1,  bmin_s2,  bmin_arm;
  logic bhour_s1, bhour_s2, bhour_arm;

  logic carry_edge, bmin_edge, bhour_edge;

  assign carry_edge = carry_s1 & ~carry_s2 & carry_arm;
  assign bmin_edge  = bmin_s1  & ~bmin_s2  & bmin_arm;
  assign bhour_edge = bhour_s1 & ~bhour_s2 & bhour_arm;

  // Minute increment: returns {wrap, tens, units}; wrap flags 59 -> 00.
  function automatic logic [8:0] inc_min(input logic [3:0] mh, input logic [3:0] ml);
    logic [8:0] r;
    r = {1'b0, mh, ml + 4'd1};
    if (ml == 4'd9) begin
      if (mh == 4'd5) r = {1'b1, 4'd0, 4'd0};
      else            r = {1'b0, mh + 4'd1, 4'd0};
    end
    return r;
  endfunction

  // Hour increment: returns {pm, tens, units} following the selected format.
  function automatic logic [8:0] inc_hour(input logic [3:0] hh, input logic [3:0] hl,
                                          input logic p);
    logic [8:0] r;
    r = {p, hh, hl + 4'd1};
    if (H24) begin
      if (hh == 4'd2 && hl == 4'd3) r = {p, 4'd0, 4'd0};
      else if (hl == 4'd9)          r = {p, hh + 4'd1, 4'd0};
    end else begin
      if (hh == 4'd1 && hl == 4'd2)      r = {p, 4'd0, 4'd1};
      else if (hh == 4'd1 && hl == 4'd1) r = {~p, 4'd1, 4'd2};
      else if (hl == 4'd9)               r = {p, 4'd1, 4'd0};
    end
    return r;
  endfunction

  logic [8:0] min_inc, hour_inc;
  logic [7:0] min_nxt;
  logic [8:0] hour_nxt;
  logic       rollover;

  // Next time value: carry-driven counting in run mode, buttons in set mode.
  always_comb begin
    min_inc  = inc_min(min_high, min_low);
    hour_inc = inc_hour(hour_high, hour_low, pm);
    min_nxt  = {min_high, min_low};
    hour_nxt = {pm, hour_high, hour_low};
    rollover = 1'b0;
    if (!set_en) begin
      if (carry_edge) begin
        min_nxt = min_inc[7:0];
        if (min_inc[8]) begin
          hour_nxt = hour_inc;
          if (H24) rollover = (hour_high == 4'd2) && (hour_low == 4'd3);
          else     rollover = (hour_high == 4'd1) && (hour_low == 4'd1) && pm;
        end
      end
    end else begin
      if (bmin_edge)  min_nxt  = min_inc[7:0];
      if (bhour_edge) hour_nxt = hour_inc;
    end
  end

  // Input history chains; they run in every mode so set-mode exit is edge-free.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      carry_s1  <= 1'b0;
      carry_s2  <= 1'b0;
      carry_arm <= 1'b0;
      bmin_s1   <= 1'b0;
      bmin_s2   <= 1'b0;
      bmin_arm  <= 1'b0;
      bhour_s1  <= 1'b0;
      bhour_s2  <= 1'b0;
      bhour_arm <= 1'b0;
    end else begin
      carry_s1  <= min_carry;
      carry_s2  <= carry_s1;
      carry_arm <= carry_arm | ~min_carry;
      bmin_s1   <= btn_min;
      bmin_s2   <= bmin_s1;
      bmin_arm  <= bmin_arm | ~btn_min;
      bhour_s1  <= btn_hour;
      bhour_s2  <= bhour_s1;
      bhour_arm <= bhour_arm | ~btn_hour;
    end
  end

  // Time registers and the registered day-rollover pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      min_low   <= 4'd0;
      min_high  <= 4'd0;
      hour_low  <= H24 ? 4'd0 : 4'd2;
      hour_high <= H24 ? 4'd0 : 4'd1;
      pm        <= 1'b0;
      day_pulse <= 1'b0;
    end else begin
      min_high  <= min_nxt[7:4];
      min_low   <= min_nxt[3:0];
      pm        <= hour_nxt[8];
      hour_high <= hour_nxt[7:4];
      hour_low  <= hour_nxt[3:0];
      day_pulse <= rollover;
    end
  end

endmodule

`default_nettype wire
